// File: rtl/onion_pwm_fade_sched_pkg.sv
// Shared definitions for the ONION PWM fade scheduler: word offsets,
// register field positions and the per-channel FSM encoding.
package onion_pwm_fade_sched_pkg;

  localparam int NUM_CH = 3;

  // Word offsets, compared against WBs_ADR_i[9:2]
  localparam logic [7:0] OFF_CFG0     = 8'h00;
  localparam logic [7:0] OFF_CFG1     = 8'h01;
  localparam logic [7:0] OFF_CFG2     = 8'h02;
  localparam logic [7:0] OFF_STATUS   = 8'h03;
  localparam logic [7:0] OFF_PRESCALE = 8'h04;
  localparam logic [7:0] OFF_CUR0     = 8'h05;
  localparam logic [7:0] OFF_CUR1     = 8'h06;
  localparam logic [7:0] OFF_CUR2     = 8'h07;

  // Field positions
  localparam int CFG_STEP_LSB = 8;
  localparam int CFG_IVL_LSB  = 16;
  localparam int CFG_GO_BIT   = 31;
  localparam int ST_DONE_LSB  = 8;
  localparam int ST_IRQEN_LSB = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } fade_state_e;

  // Byte-lane merge of a write into an existing 32-bit register image
  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/onion_pwm_fade_sched_channel.sv
// One fade channel: latches target/step/interval on GO and walks the
// current duty toward the target, one step per (interval+1) ticks.
module onion_fade_channel
  import onion_pwm_fade_sched_pkg::*;
#(
  parameter int RES = 8,
  parameter int IVB = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           go,
  input  logic           cur_wr,
  input  logic [RES-1:0] cur_data,
  input  logic [RES-1:0] target,
  input  logic [7:0]     step,
  input  logic [IVB-1:0] interval,
  output logic [RES-1:0] cur,
  output logic           busy,
  output logic           done_pulse
);

  // Wide enough for an 8-bit step on top of an 8-bit duty without wrap
  localparam int AW = 9;

  fade_state_e    state;
  logic [RES-1:0] tgt_l;
  logic [7:0]     step_l;
  logic [IVB-1:0] ivl_l, cnt;
  logic [AW-1:0]  cur_x, tgt_x, stp_x, sum_x, dif_x, nxt_x;
  logic [RES-1:0] cur_nxt;

  // Saturating move toward the latched target; never overshoots
  always_comb begin
    cur_x = AW'(cur);
    tgt_x = AW'(tgt_l);
    stp_x = AW'(step_l);
    sum_x = cur_x + stp_x;
    dif_x = cur_x - stp_x;
    if (cur_x < tgt_x)
      nxt_x = (sum_x >= tgt_x) ? tgt_x : sum_x;
    else
      nxt_x = ((stp_x > cur_x) || (dif_x <= tgt_x)) ? tgt_x : dif_x;
    cur_nxt = nxt_x[RES-1:0];
  end

  // Completion strobe lands on the same edge that drops busy (or, for a
  // GO that is already on target, the edge that accepts the GO)
  assign done_pulse = ~cur_wr & (
                        (go & (state == S_IDLE) & (cur == target)) |
                        (~go & (state == S_STEP) & (cur_nxt == tgt_l)));

  // Fade FSM; a CUR write beats GO, GO beats the running fade. STEP also
  // counts ticks so the step spacing stays exactly interval+1 ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cur    <= '0;
      busy   <= 1'b0;
      tgt_l  <= '0;
      step_l <= '0;
      ivl_l  <= '0;
      cnt    <= '0;
    end else if (cur_wr) begin
      cur   <= cur_data;
      state <= S_IDLE;
      busy  <= 1'b0;
    end else if (go) begin
      tgt_l  <= target;
      step_l <= (step == 8'd0) ? 8'd1 : step;
      ivl_l  <= interval;
      cnt    <= interval;
      if ((state == S_IDLE) && (cur == target)) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        state <= S_RUN;
        busy  <= 1'b1;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (tick) begin
            if (cnt == '0) begin
              state <= S_STEP;
              cnt   <= ivl_l;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        S_STEP: begin
          cur <= cur_nxt;
          if (cur_nxt == tgt_l) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (tick && (cnt == '0)) begin
            state <= S_STEP;
            cnt   <= ivl_l;
          end else begin
            state <= S_RUN;
            if (tick) cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/onion_pwm_fade_sched.sv
// Wishbone fade scheduler for the three ONION_PWM duty inputs: bus decode,
// shared prescaler, STATUS/IRQ, and three fade channels.
module onion_pwm_fade_sched
  import onion_pwm_fade_sched_pkg::*;
#(
  parameter int          PWM_RESOLUTION_BITS = 8,
  parameter int          INTERVAL_BITS       = 12,
  parameter logic [31:0] DEFAULT_REG_VALUE   = 32'hDEF_FAB_AC
) (
  input  logic                               WBs_CLK_i,
  input  logic                               WBs_RST_n_i,
  input  logic [16:0]                        WBs_ADR_i,
  input  logic                               WBs_CYC_i,
  input  logic                               WBs_STB_i,
  input  logic                               WBs_WE_i,
  input  logic [3:0]                         WBs_BYTE_STB_i,
  input  logic [31:0]                        WBs_DAT_i,
  output logic [31:0]                        WBs_DAT_o,
  output logic                               WBs_ACK_o,
  output logic [3*PWM_RESOLUTION_BITS-1:0]   DUTY_o,
  output logic [2:0]                         BUSY_o,
  output logic                               FADE_IRQ_o
);

  localparam int RES = PWM_RESOLUTION_BITS;
  localparam int IVB = INTERVAL_BITS;

  logic        ack, ack_nxt, wr, tick, st_we, pre_we, irq_r;
  logic [7:0]  off;
  logic [NUM_CH-1:0][RES-1:0] tgt_r, cur_w;
  logic [NUM_CH-1:0][7:0]     step_r;
  logic [NUM_CH-1:0][IVB-1:0] ivl_r;
  logic [NUM_CH-1:0][31:0]    cfg_old, cfg_new;
  logic [NUM_CH-1:0]          cfg_we, go, cur_we, busy_w, done_w;
  logic [2:0]  done_r, irq_en_r, done_nxt, irq_en_nxt, clr;
  logic [15:0] pre_r, pcnt, pre_new;
  logic [31:0] pre_word, rd;
  logic        unused;

  // Bus decode and next-state terms for the CSRs
  always_comb begin
    ack_nxt = WBs_CYC_i & WBs_STB_i & ~ack;
    wr      = ack_nxt & WBs_WE_i;
    off     = WBs_ADR_i[9:2];
    st_we   = wr && (off == OFF_STATUS);
    pre_we  = wr && (off == OFF_PRESCALE);
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_old[i] = '0;
      cfg_old[i][RES-1:0]                = tgt_r[i];
      cfg_old[i][CFG_STEP_LSB +: 8]      = step_r[i];
      cfg_old[i][CFG_IVL_LSB +: IVB]     = ivl_r[i];
      cfg_new[i] = merge_be(cfg_old[i], WBs_DAT_i, WBs_BYTE_STB_i);
      cfg_we[i]  = wr && (off == OFF_CFG0 + 8'(i));
      go[i]      = cfg_we[i] & WBs_BYTE_STB_i[3] & WBs_DAT_i[CFG_GO_BIT];
      cur_we[i]  = wr && (off == OFF_CUR0 + 8'(i)) && WBs_BYTE_STB_i[0];
    end
    pre_word   = merge_be({16'h0, pre_r}, WBs_DAT_i, WBs_BYTE_STB_i);
    pre_new    = pre_word[15:0];
    clr        = (st_we & WBs_BYTE_STB_i[1]) ? WBs_DAT_i[ST_DONE_LSB +: 3] : 3'b000;
    irq_en_nxt = (st_we & WBs_BYTE_STB_i[2]) ? WBs_DAT_i[ST_IRQEN_LSB +: 3] : irq_en_r;
    // a completion in the same cycle as its W1C keeps the bit set
    done_nxt   = (done_r & ~clr) | done_w;
    tick       = (pcnt == 16'd0);
  end

  // Registered bus ack, CSRs, prescaler and the interrupt
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      ack      <= 1'b0;
      tgt_r    <= '0;
      step_r   <= '0;
      ivl_r    <= '0;
      done_r   <= '0;
      irq_en_r <= '0;
      irq_r    <= 1'b0;
      pre_r    <= '0;
      pcnt     <= '0;
    end else begin
      ack <= ack_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we[i]) begin
          tgt_r[i]  <= cfg_new[i][RES-1:0];
          step_r[i] <= cfg_new[i][CFG_STEP_LSB +: 8];
          ivl_r[i]  <= cfg_new[i][CFG_IVL_LSB +: IVB];
        end
      end
      done_r   <= done_nxt;
      irq_en_r <= irq_en_nxt;
      irq_r    <= |(done_nxt & irq_en_nxt);
      if (pre_we) begin
        pre_r <= pre_new;
        pcnt  <= pre_new;
      end else if (tick) begin
        pcnt <= pre_r;
      end else begin
        pcnt <= pcnt - 16'd1;
      end
    end
  end

  // Combinational read mux
  always_comb begin
    rd = DEFAULT_REG_VALUE;
    case (off)
      OFF_CFG0:     rd = {busy_w[0], cfg_old[0][30:0]};
      OFF_CFG1:     rd = {busy_w[1], cfg_old[1][30:0]};
      OFF_CFG2:     rd = {busy_w[2], cfg_old[2][30:0]};
      OFF_STATUS:   rd = {13'd0, irq_en_r, 5'd0, done_r, 5'd0, busy_w};
      OFF_PRESCALE: rd = {16'd0, pre_r};
      OFF_CUR0:     rd = 32'(cur_w[0]);
      OFF_CUR1:     rd = 32'(cur_w[1]);
      OFF_CUR2:     rd = 32'(cur_w[2]);
      default:      rd = DEFAULT_REG_VALUE;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    onion_fade_channel #(.RES(RES), .IVB(IVB)) u_ch (
      .clk        (WBs_CLK_i),
      .rst_n      (WBs_RST_n_i),
      .tick       (tick),
      .go         (go[g]),
      .cur_wr     (cur_we[g]),
      .cur_data   (WBs_DAT_i[RES-1:0]),
      .target     (cfg_new[g][RES-1:0]),
      .step       (cfg_new[g][CFG_STEP_LSB +: 8]),
      .interval   (cfg_new[g][CFG_IVL_LSB +: IVB]),
      .cur        (cur_w[g]),
      .busy       (busy_w[g]),
      .done_pulse (done_w[g])
    );
  end

  assign WBs_DAT_o  = rd;
  assign WBs_ACK_o  = ack;
  assign DUTY_o     = cur_w;
  assign BUSY_o     = busy_w;
  assign FADE_IRQ_o = irq_r;
  assign unused     = ^{WBs_ADR_i[16:10], WBs_ADR_i[1:0], WBs_DAT_i, cfg_new, pre_word[31:16]};

endmodule

// File: tb/tb_onion_pwm_fade_sched.sv
// Bench for onion_pwm_fade_sched: behavioural fade model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_onion_pwm_fade_sched;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [16:0] adr = '0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ack, irq;
  logic [23:0] duty;
  logic [2:0]  busy;

  onion_pwm_fade_sched dut (
    .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .WBs_ADR_i(adr), .WBs_CYC_i(cyc),
    .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_BYTE_STB_i(be), .WBs_DAT_i(dat_i),
    .WBs_DAT_o(dat_o), .WBs_ACK_o(ack), .DUTY_o(duty), .BUSY_o(busy),
    .FADE_IRQ_o(irq));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0]  m_cur[3], m_tgt[3], m_step[3], c_tgt[3], c_step[3];
  bit [11:0] c_ivl[3];
  int        m_ivl[3], m_left[3];
  bit        m_busy[3], m_pend[3];
  bit [2:0]  m_done, m_irq_en, dset, clr;
  bit [15:0] m_pre, m_pc;
  bit        m_ack, m_irq, ack_n, wr, tick, go_m, cw_m;
  int        off_m;

  function automatic bit [7:0] move(input bit [7:0] c, input bit [7:0] t, input bit [7:0] s);
    int ci = c, ti = t, si = s;
    if (ci < ti) return (ci + si >= ti) ? t : 8'(ci + si);
    return (ci - si <= ti) ? t : 8'(ci - si);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        m_cur[c] = 0; m_tgt[c] = 0; m_step[c] = 0; c_tgt[c] = 0; c_step[c] = 0;
        c_ivl[c] = 0; m_ivl[c] = 0; m_left[c] = 0; m_busy[c] = 0; m_pend[c] = 0;
      end
      m_done = 0; m_irq_en = 0; m_pre = 0; m_pc = 0; m_ack = 0; m_irq = 0;
    end else begin
      ack_n = cyc && stb && !m_ack;
      wr    = ack_n && we;
      off_m = int'(adr[9:2]);
      tick  = (m_pc == 0);
      dset = 0; clr = 0;
      if (wr && off_m == 4) begin
        m_pre = {be[1] ? dat_i[15:8] : m_pre[15:8], be[0] ? dat_i[7:0] : m_pre[7:0]};
        m_pc  = m_pre;
      end else if (tick) m_pc = m_pre;
      else m_pc = m_pc - 1;
      for (int c = 0; c < 3; c++) begin
        cw_m = wr && off_m == 5 + c && be[0];
        go_m = 0;
        if (wr && off_m == c) begin
          if (be[0]) c_tgt[c] = dat_i[7:0];
          if (be[1]) c_step[c] = dat_i[15:8];
          if (be[2]) c_ivl[c][7:0] = dat_i[23:16];
          if (be[3]) c_ivl[c][11:8] = dat_i[27:24];
          go_m = be[3] && dat_i[31];
        end
        if (cw_m) begin
          m_cur[c] = dat_i[7:0]; m_busy[c] = 0; m_pend[c] = 0;
        end else if (go_m) begin
          m_tgt[c]  = c_tgt[c];
          m_step[c] = (c_step[c] == 0) ? 8'd1 : c_step[c];
          m_ivl[c]  = c_ivl[c];
          m_left[c] = m_ivl[c] + 1;
          m_pend[c] = 0;
          if (!m_busy[c] && m_cur[c] == m_tgt[c]) dset[c] = 1;
          else m_busy[c] = 1;
        end else if (m_busy[c]) begin
          if (m_pend[c]) begin
            m_pend[c] = 0;
            m_cur[c] = move(m_cur[c], m_tgt[c], m_step[c]);
            if (m_cur[c] == m_tgt[c]) begin m_busy[c] = 0; dset[c] = 1; end
          end
          if (m_busy[c] && tick) begin
            m_left[c]--;
            if (m_left[c] == 0) begin m_pend[c] = 1; m_left[c] = m_ivl[c] + 1; end
          end
        end
      end
      if (wr && off_m == 3) begin
        if (be[1]) clr = dat_i[10:8];
        if (be[2]) m_irq_en = dat_i[18:16];
      end
      m_done = (m_done & ~clr) | dset;
      m_irq  = |(m_done & m_irq_en);
      m_ack  = ack_n;
    end
  end

  function automatic bit [31:0] m_read(input int o);
    bit [2:0] b;
    b = {m_busy[2], m_busy[1], m_busy[0]};
    case (o)
      0, 1, 2: return {m_busy[o], 3'b0, c_ivl[o], c_step[o], c_tgt[o]};
      3:       return {13'd0, m_irq_en, 5'd0, m_done, 5'd0, b};
      4:       return {16'd0, m_pre};
      5, 6, 7: return {24'd0, m_cur[o-5]};
      default: return 32'hDEFFABAC;
    endcase
  endfunction

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("duty", duty, {m_cur[2], m_cur[1], m_cur[0]});
    chk("busy", busy, {m_busy[2], m_busy[1], m_busy[0]});
    chk("irq",  irq,  m_irq);
    chk("ack",  ack,  m_ack);
  end

  int  irq_rises = 0;
  bit  irq_q = 0;
  always @(negedge clk) begin
    if (irq && !irq_q) irq_rises++;
    irq_q = irq;
  end

  // ---------------- bus tasks ----------------
  task automatic wb_xfer(input bit w, input bit [16:0] a, input bit [31:0] d,
                         input bit [3:0] b, output bit [31:0] rdat);
    @(posedge clk); #1;
    adr = a; dat_i = d; be = b; we = w; cyc = 1; stb = 1;
    @(posedge clk); #1;
    checks++;
    if (!ack) begin errors++; $display("FAIL ack_timeout adr=%0h actual=0 expected=1", a); end
    rdat = dat_o;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb_write(input bit [16:0] a, input bit [31:0] d, input bit [3:0] b = 4'hF);
    bit [31:0] dummy;
    wb_xfer(1, a, d, b, dummy);
  endtask

  task automatic rd_model(input string name, input bit [16:0] a);
    bit [31:0] r;
    wb_xfer(0, a, 32'h0, 4'hF, r);
    chk(name, r, m_read(int'(a[9:2])));
  endtask

  task automatic rd_lit(input string name, input bit [16:0] a, input bit [31:0] exp);
    bit [31:0] r;
    wb_xfer(0, a, 32'h0, 4'hF, r);
    chk(name, r, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int ch, input int budget, input string name);
    for (int i = 0; i < budget && busy[ch]; i++) begin @(posedge clk); #1; end
    chk(name, busy[ch], 1'b0);
  endtask

  // ---------------- stimulus ----------------
  bit [7:0] vals[8];
  int       tms[3][8], nchg[3], n;
  bit [7:0] prev[3];
  bit       saw_wrap;

  initial begin
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    #1;
    chk("rst_duty", duty, 24'h0);
    chk("rst_busy", busy, 3'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_ack", ack, 1'b0);
    rd_lit("default_read", 17'h20, 32'hDEFFABAC);
    rd_lit("cfg0_reset", 17'h00, 32'h0);

    // Basic ramp 0x10 -> 0x40, step 0x10, interval 1, tick every clock
    wb_write(17'h10, 32'h0);
    wb_write(17'h14, 32'h10);
    wb_write(17'h0C, 32'h0001_0000, 4'b0100);
    wb_write(17'h00, 32'h8001_1040);
    n = 0; prev[0] = duty[7:0];
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (duty[7:0] != prev[0] && n < 8) begin vals[n] = duty[7:0]; tms[0][n] = i; n++; end
      prev[0] = duty[7:0];
    end
    chk("ramp_nchg", n, 3);
    chk("ramp_v0", vals[0], 8'h20);
    chk("ramp_v1", vals[1], 8'h30);
    chk("ramp_v2", vals[2], 8'h40);
    chk("ramp_gap1", tms[0][1] - tms[0][0], 2);
    chk("ramp_gap2", tms[0][2] - tms[0][1], 2);
    chk("ramp_busy", busy[0], 1'b0);
    chk("ramp_irq", irq, 1'b1);
    rd_lit("ramp_status", 17'h0C, 32'h0001_0100);
    wb_write(17'h0C, 32'h0000_0100, 4'b0010);
    chk("w1c_irq", irq, 1'b0);

    // Clamping at both ends
    wb_write(17'h1C, 32'h05);
    wb_write(17'h08, 32'h8000_1000);
    saw_wrap = 0; n = 0; prev[2] = duty[23:16];
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (duty[23:16] == 8'hF5) saw_wrap = 1;
      if (duty[23:16] != prev[2]) n++;
      prev[2] = duty[23:16];
    end
    chk("clamp_lo_wrap", saw_wrap, 1'b0);
    chk("clamp_lo_nchg", n, 1);
    chk("clamp_lo_val", duty[23:16], 8'h00);
    wb_write(17'h1C, 32'hF8);
    wb_write(17'h08, 32'h8000_20FF);
    cycles(20);
    chk("clamp_hi_val", duty[23:16], 8'hFF);

    // Retarget mid-fade, then abort with a CUR write
    wb_write(17'h0C, 32'h0002_0700, 4'b0110);
    wb_write(17'h18, 32'h00);
    wb_write(17'h04, 32'h8003_2080);
    irq_rises = 0;
    for (int i = 0; i < 100 && duty[15:8] != 8'h40; i++) begin @(posedge clk); #1; end
    chk("retgt_reach40", duty[15:8], 8'h40);
    wb_write(17'h04, 32'h8003_2020);
    wait_idle(1, 100, "retgt_idle");
    cycles(4);
    chk("retgt_val", duty[15:8], 8'h20);
    chk("retgt_one_done", irq_rises, 1);
    wb_write(17'h0C, 32'h0000_0200, 4'b0010);
    wb_write(17'h04, 32'h8003_10A0);
    cycles(6);
    irq_rises = 0;
    wb_write(17'h18, 32'h55);
    chk("abort_busy", busy[1], 1'b0);
    chk("abort_duty", duty[15:8], 8'h55);
    cycles(30);
    chk("abort_no_done", irq_rises, 0);

    // Three channels concurrently on a prescaled time base
    wb_write(17'h0C, 32'h0000_0700, 4'b0110);
    wb_write(17'h10, 32'h3);
    for (int c = 0; c < 3; c++) wb_write(17'(32'h14 + 4 * c), 32'h0);
    wb_write(17'h08, 32'h8005_1030);
    wb_write(17'h04, 32'h8002_1030);
    wb_write(17'h00, 32'h8000_1030);
    for (int c = 0; c < 3; c++) begin nchg[c] = 0; prev[c] = duty[8*c +: 8]; end
    for (int i = 0; i < 400 && busy != 3'b0; i++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 3; c++) begin
        if (duty[8*c +: 8] != prev[c] && nchg[c] < 8) begin tms[c][nchg[c]] = i; nchg[c]++; end
        prev[c] = duty[8*c +: 8];
      end
    end
    chk("multi_busy", busy, 3'b0);
    chk("multi_n0", nchg[0], 3);
    chk("multi_n2", nchg[2], 3);
    chk("multi_gap0", tms[0][2] - tms[0][1], 4);
    chk("multi_gap1", tms[1][2] - tms[1][1], 12);
    chk("multi_gap2", tms[2][2] - tms[2][1], 24);
    rd_lit("multi_status", 17'h0C, 32'h0000_0700);

    // Asynchronous reset in the middle of a fade
    wb_write(17'h14, 32'h0);
    wb_write(17'h00, 32'h8001_10F0);
    cycles(20);
    chk("pre_rst_busy", busy[0], 1'b1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("async_duty", duty, 24'h0);
    chk("async_busy", busy, 3'b0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1;
    cycles(40);
    chk("post_rst_duty", duty, 24'h0);
    chk("post_rst_busy", busy, 3'b0);
    rd_lit("post_rst_cfg0", 17'h00, 32'h0);

    // Random traffic against the model
    for (int it = 0; it < 400; it++) begin
      int op, ch;
      bit [31:0] d;
      bit [3:0]  b;
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, 2);
      b  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case (op)
        0, 1, 2: begin
          d = {($urandom_range(0, 3) != 0), 3'b0, 12'($urandom_range(0, 3)),
               8'($urandom_range(0, 8'h50)), 8'($urandom)};
          wb_write(17'(4 * ch), d, b);
        end
        3: wb_write(17'(32'h14 + 4 * ch), $urandom, b);
        4: wb_write(17'h0C, $urandom, 4'($urandom));
        5: wb_write(17'h10, 32'($urandom_range(0, 3)), 4'hF);
        6, 7: rd_model("rand_read", 17'(4 * $urandom_range(0, 9)));
        default: cycles($urandom_range(1, 10));
      endcase
    end
    cycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onion_pwm_fade_sched.md
Name: onion_pwm_fade_sched

Overview:
- Wishbone-slave fade scheduler that sequences the duty-cycle inputs of the three ONION_PWM channels (R/G/B).
- Firmware programs a target duty, a step size and a step interval per channel, then sets GO.
- The block ramps each channel's current duty toward its target on a shared prescaled time base. It raises a maskable interrupt when a fade completes.
- Sits beside the PWM register block; the PWM instances take their duty_cycle from DUTY_o slices.

Parameters:
- PWM_RESOLUTION_BITS, 8, width of each duty value (max 8, the field width).
- INTERVAL_BITS, 12, width of the per-channel step-interval field (max 12).
- DEFAULT_REG_VALUE, 32'hDEF_FAB_AC, read value for unimplemented addresses.

Ports:
- WBs_CLK_i  in  1  single clock, bus and fade logic
- WBs_RST_n_i  in  1  asynchronous active-low reset
- WBs_ADR_i  in  17  byte address; [9:2] decoded
- WBs_CYC_i  in  1  cycle select
- WBs_STB_i  in  1  strobe
- WBs_WE_i  in  1  write enable
- WBs_BYTE_STB_i  in  4  byte lanes
- WBs_DAT_i  in  32  write data
- WBs_DAT_o  out  32  read data (combinational)
- WBs_ACK_o  out  1  acknowledge
- DUTY_o  out  3*PWM_RESOLUTION_BITS  current duty; ch0 in the LSBs
- BUSY_o  out  3  channel fading
- FADE_IRQ_o  out  1  OR of (done & irq_en)

Behaviour:
- Reset (WBs_RST_n_i low, asynchronous): all registers, counters, DUTY_o, BUSY_o, FADE_IRQ_o and WBs_ACK_o go to 0; all FSMs go to IDLE.
- Bus timing:
  - ACK_nxt = CYC & STB & ~ACK; ACK registered, giving one wait state.
  - Writes qualify on the same term plus WE; byte lanes are honoured.
- Register map (offsets):
  - 0x00/0x04/0x08 CFG_x:
    - [7:0] target
    - [15:8] step (0 treated as 1)
    - [16+INTERVAL_BITS-1:16] interval
    - [31] GO; write 1 starts the fade; reads back BUSY_o[x].
  - 0x0C STATUS:
    - [2:0] busy (RO)
    - [10:8] done (sticky, W1C)
    - [18:16] irq_en (RW)
  - 0x10 PRESCALE: [15:0]; the tick pulses one cycle every PRESCALE+1 clocks. PRESCALE=0 gives a tick every clock.
  - 0x14/0x18/0x1C CUR_x: read returns the current duty. A write forces the current duty and aborts any fade.
  - Unused fields read 0; other addresses return DEFAULT_REG_VALUE.
- Prescaler: a 16-bit down-counter reloads to PRESCALE on tick. A write to PRESCALE reloads the counter on the next clock.
- Channel FSM states:
  - IDLE:
    - GO with cur==target: set done[x] next cycle, stay IDLE.
    - GO with cur!=target: load interval counter, go RUN, busy=1.
  - RUN: on tick, if the interval counter is 0, go STEP and reload the counter; otherwise decrement.
  - STEP (one cycle):
    - cur moves toward target by step, using 9-bit intermediate arithmetic.
    - Clamp to target, with no overshoot and no wrap past 0 or 2^RES-1.
    - If the new cur==target, go IDLE, busy=0 and set done[x]; otherwise go back to RUN.
- Latency: the first duty change occurs (interval+1) ticks after GO; subsequent changes follow every interval+1 ticks.
- Boundary cases:
  - GO in RUN/STEP: latch the new target/step/interval, reload the counter, stay RUN. No done is generated for the abandoned fade.
  - CUR_x write: cur is updated, the FSM goes IDLE with busy=0 and no done. CUR write wins over GO in the same cycle, which cannot occur through a single bus port.
  - Done set and W1C clear in the same cycle: set wins.
  - Target bits at or above PWM_RESOLUTION_BITS are ignored.
  - The target register may be rewritten without GO; the change takes effect only at the next GO, because the FSM uses latched copies.
  - Reset mid-fade: DUTY_o goes to 0 immediately.
- FADE_IRQ_o is registered and is high while any (done & irq_en) bit is set.

Decomposition:
- Shared package/include: register offsets, field bit positions, FSM state encoding (IDLE/RUN/STEP, 2 bits).
- Sub-module onion_fade_channel is instantiated 3 times. It takes tick, go, cur-write strobe/data, target/step/interval, and outputs cur, busy, done_pulse.
- The top level holds the bus decode, the prescaler, STATUS and the IRQ.

Test Plan:
1. Reset release → all outputs 0. A read of 0x20 returns 32'hDEFFABAC; a read of CFG_0 returns 0.
2. PRESCALE=0, CUR_0=0x10, CFG_0: target 0x40, step 0x10, interval 1, GO.
   - DUTY ch0 steps 0x20, 0x30, 0x40, each every 2 clocks.
   - busy[0] falls at 0x40; done[0]=1; with irq_en[0]=1, FADE_IRQ_o=1.
   - W1C of 0x100 clears the IRQ.
3. Downward clamp: cur 0x05, target 0x00, step 0x10 → a single step to 0x00 with no wrap to 0xF5. Similarly, cur 0xF8, target 0xFF, step 0x20 → 0xFF.
4. Retarget mid-fade: during the ch1 ramp 0x00→0x80, write GO with target 0x20 at cur 0x40.
   - Ramps down to 0x20; only one done pulse.
   - Writing CUR_1=0x55 mid-fade: busy=0, DUTY=0x55, no done.
5. Three channels concurrently with PRESCALE=3 and intervals 0/2/5 → step spacing of 4/12/24 clocks respectively. Independent done bits.
6. Assert WBs_RST_n_i mid-fade, asynchronously between clock edges → DUTY_o and BUSY_o are 0 immediately. After release, nothing restarts without GO.
